// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the word-assembling UART receiver.
// The PARITY state exists only when UART_WORD_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_WORD_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver that assembles NUM_BYTES bytes into one word behind a valid/ready output.
// Define UART_WORD_RX_PARITY_EN to add an even-parity bit after the data bits (8E1 instead of 8N1).
module uart_word_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 444,
  parameter int NUM_BYTES    = 12,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   CLK_I,
  input  logic                   RSTL_I,
  input  logic                   UART_RX_I,
  input  logic                   RX_READY_I,
  output logic                   RX_VALID_O,
  output logic [NUM_BYTES*8-1:0] RX_DATA_O,
  output logic                   FRAME_ERR_O,
  output logic                   OVERRUN_O,
  output logic                   TIMEOUT_O,
  output logic [2:0]             state_dbg
);

  localparam int W         = NUM_BYTES * BITS_PER_BYTE;
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int KW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(NUM_BYTES - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CYCLES - 1);

  state_t        state;
  logic          rx_s, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [W-1:0]  asm_word, next_word;
  logic [KW-1:0] k;
  logic [TW-1:0] idle_cnt;
  logic          bit_tick, start_edge, stop_eval, stop_ok;
  logic          byte_commit, frame_bad, word_done, timeout_hit;
`ifdef UART_WORD_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_rx_sync u_sync (
    .clk   (CLK_I),
    .rst_n (RSTL_I),
    .din   (UART_RX_I),
    .dout  (rx_s)
  );

  assign state_dbg = state;

  // A start needs a real high-to-low edge, so a line held low (break, or a
  // low stop bit) is never mistaken for a new frame.
  assign start_edge = rx_prev && !rx_s;
  assign bit_tick   = (clk_cnt == FULL_M1);
  assign stop_eval  = (state == ST_STOP) && bit_tick;

  always_comb begin
    stop_ok = rx_s;
`ifdef UART_WORD_RX_PARITY_EN
    stop_ok = rx_s && !parity_err;
`endif
  end

  assign byte_commit = stop_eval && stop_ok;
  assign frame_bad   = stop_eval && !stop_ok;
  assign word_done   = byte_commit && (k == LAST_K);
  assign timeout_hit = (state == ST_IDLE) && (k != '0) && !start_edge && (idle_cnt == TO_M1);

  always_comb begin
    next_word = asm_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (k == KW'(i)) next_word[i*8 +: 8] = shreg;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state   <= ST_IDLE;
      rx_prev <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_WORD_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_edge) state <= ST_START;
        end
        ST_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_WORD_RX_PARITY_EN
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) state <= ST_PARITY;
`else
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) state <= ST_STOP;
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_WORD_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            clk_cnt    <= '0;
            parity_err <= (^shreg) != rx_s;
            state      <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      k        <= '0;
      asm_word <= '0;
      idle_cnt <= '0;
    end else begin
      if (byte_commit) begin
        asm_word <= next_word;
        k        <= word_done ? '0 : k + 1'b1;
      end else if (frame_bad || timeout_hit) begin
        k <= '0;
      end
      if (state == ST_IDLE && k != '0 && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
      else                                             idle_cnt <= '0;
    end
  end

  // Output register: a completed word loads when the slot is empty or being
  // consumed this cycle; otherwise it is dropped and the held word kept.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      RX_VALID_O  <= 1'b0;
      RX_DATA_O   <= '0;
      FRAME_ERR_O <= 1'b0;
      OVERRUN_O   <= 1'b0;
      TIMEOUT_O   <= 1'b0;
    end else begin
      FRAME_ERR_O <= frame_bad;
      TIMEOUT_O   <= timeout_hit;
      OVERRUN_O   <= word_done && RX_VALID_O && !RX_READY_I;
      if (word_done && (!RX_VALID_O || RX_READY_I)) begin
        RX_DATA_O  <= next_word;
        RX_VALID_O <= 1'b1;
      end else if (RX_VALID_O && RX_READY_I) begin
        RX_VALID_O <= 1'b0;
      end
    end
  end

endmodule
